// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver and scan-code decoder
//
// Deserializes 11-bit device-to-host PS/2 frames, checks odd parity and the
// stop bit, strips E0 (extended) and F0 (break) prefixes, and presents the
// resulting scan code as a make/break strobe plus held arrow-key flags.
//
// Ports:
//   iCLK        system clock, the only clock in the block
//   iRST_n      asynchronous active-low reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_dat     raw PS/2 data pin (asynchronous)
//   key_in      last completed non-prefix scan code
//   key_en      one-cycle strobe on a make
//   key_rel     one-cycle strobe on a break
//   key_ext     code in key_in was preceded by E0
//   key_up/down/left/right  held while the extended arrow key is pressed
//   frame_err   one-cycle strobe on parity error, bad stop bit or timeout
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_rel,
    output logic       key_ext,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Synchronizers and clock glitch filter (reset to bus idle level)
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_clk_q, filt_clk_d, filt_prev_q;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall;

    // Receiver state
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [15:0]    wdog_q, wdog_d;
    logic           ext_q, ext_d, brk_q, brk_d;

    // Registered outputs
    logic [7:0]     key_in_q, key_in_d;
    logic           key_en_q, key_en_d, key_rel_q, key_rel_d, key_ext_q, key_ext_d;
    logic           up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic           frame_err_q, frame_err_d;

    // The filtered clock only moves after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the count.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_clk_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_in_d    = key_in_q;
        key_ext_d   = key_ext_q;
        up_d        = up_q;
        down_d      = down_q;
        left_d      = left_q;
        right_d     = right_q;
        key_en_d    = 1'b0;
        key_rel_d   = 1'b0;
        frame_err_d = 1'b0;

        if (fall || state_q == S_IDLE) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (dat_s2_q && (^{par_q, shift_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            key_in_d  = shift_q;
                            key_ext_d = ext_q;
                            key_rel_d = brk_q;
                            key_en_d  = ~brk_q;
                            ext_d     = 1'b0;
                            brk_d     = 1'b0;
                            // Arrow flags follow make/break of extended codes only
                            if (ext_q) begin
                                case (shift_q)
                                    8'h75: up_d    = ~brk_q;
                                    8'h72: down_d  = ~brk_q;
                                    8'h6B: left_d  = ~brk_q;
                                    8'h74: right_d = ~brk_q;
                                    default: ;
                                endcase
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled frame is abandoned, along with any pending prefix.
        if (state_q != S_IDLE && !fall && wdog_q == 16'(TIMEOUT_CYC)) begin
            state_d     = S_IDLE;
            wdog_d      = '0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wdog_q      <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_in_q    <= 8'h00;
            key_en_q    <= 1'b0;
            key_rel_q   <= 1'b0;
            key_ext_q   <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_dat;
            dat_s2_q    <= dat_s1_q;
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_clk_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wdog_q      <= wdog_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_in_q    <= key_in_d;
            key_en_q    <= key_en_d;
            key_rel_q   <= key_rel_d;
            key_ext_q   <= key_ext_d;
            up_q        <= up_d;
            down_q      <= down_d;
            left_q      <= left_d;
            right_q     <= right_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key_in    = key_in_q;
    assign key_en    = key_en_q;
    assign key_rel   = key_rel_q;
    assign key_ext   = key_ext_q;
    assign key_up    = up_q;
    assign key_down  = down_q;
    assign key_left  = left_q;
    assign key_right = right_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int HALF = 20;
    localparam int TO   = 1000;

    logic       iCLK = 1'b0;
    logic       iRST_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] key_in;
    logic       key_en, key_rel, key_ext;
    logic       key_up, key_down, key_left, key_right;
    logic       frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt = 0, rel_cnt = 0, err_cnt = 0, multi_cnt = 0;
    int en0, rel0, err0;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_in(key_in), .key_en(key_en), .key_rel(key_rel), .key_ext(key_ext),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .frame_err(frame_err)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        en_cnt  <= en_cnt + int'(key_en);
        rel_cnt <= rel_cnt + int'(key_rel);
        err_cnt <= err_cnt + int'(frame_err);
        if (int'(key_en) + int'(key_rel) + int'(frame_err) > 1) multi_cnt <= multi_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flip);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic snap();
        en0 = en_cnt; rel0 = rel_cnt; err0 = err_cnt;
    endtask

    initial begin
        wait_cyc(5);
        chk("rst_key_in", 32'(key_in), 32'h00);
        chk("rst_strobes", {key_en, key_rel, frame_err}, 0);
        chk("rst_flags", {key_ext, key_up, key_down, key_left, key_right}, 0);
        iRST_n = 1'b1;
        wait_cyc(20);

        // Single make
        snap();
        send_frame(8'h6B, 1'b0);
        chk("make_en", en_cnt - en0, 1);
        chk("make_rel", rel_cnt - rel0, 0);
        chk("make_err", err_cnt - err0, 0);
        chk("make_key", 32'(key_in), 32'h6B);
        chk("make_ext", 32'(key_ext), 0);
        chk("make_left", 32'(key_left), 0);

        // Extended arrow press
        snap();
        send_frame(8'hE0, 1'b0);
        chk("pfx_e0_nostrobe", (en_cnt - en0) + (rel_cnt - rel0) + (err_cnt - err0), 0);
        send_frame(8'h74, 1'b0);
        chk("arr_en", en_cnt - en0, 1);
        chk("arr_key", 32'(key_in), 32'h74);
        chk("arr_ext", 32'(key_ext), 1);
        chk("arr_right", 32'(key_right), 1);

        // Extended arrow release
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        chk("pfx_f0_nostrobe", (en_cnt - en0) + (rel_cnt - rel0) + (err_cnt - err0), 0);
        send_frame(8'h74, 1'b0);
        chk("brk_rel", rel_cnt - rel0, 1);
        chk("brk_en", en_cnt - en0, 0);
        chk("brk_right", 32'(key_right), 0);
        chk("brk_ext", 32'(key_ext), 1);

        // Parity error on F0 discards the break prefix
        snap();
        send_frame(8'hF0, 1'b1);
        chk("par_err", err_cnt - err0, 1);
        send_frame(8'h1C, 1'b0);
        chk("par_next_en", en_cnt - en0, 1);
        chk("par_next_rel", rel_cnt - rel0, 0);
        chk("par_next_key", 32'(key_in), 32'h1C);

        // Bad stop bit
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        chk("stop_err", err_cnt - err0, 1);
        chk("stop_key_held", 32'(key_in), 32'h1C);

        // 4-cycle clock glitch with data low must not start a frame
        snap();
        ps2_dat = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(4);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        ps2_dat = 1'b1;
        wait_cyc(TO + 100);
        chk("glitch_noerr", err_cnt - err0, 0);

        // Stalled frame after 5 bits -> one timeout error
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(TO + 100);
        chk("to_err", err_cnt - err0, 1);
        chk("to_en", en_cnt - en0, 0);
        snap();
        send_frame(8'h75, 1'b0);
        chk("to_next_en", en_cnt - en0, 1);
        chk("to_next_err", err_cnt - err0, 0);
        chk("to_next_key", 32'(key_in), 32'h75);
        chk("to_next_up", 32'(key_up), 0);

        // Reset after start + 3 data bits of E0
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        iRST_n = 1'b0;
        wait_cyc(3);
        chk("mid_rst_key", 32'(key_in), 32'h00);
        chk("mid_rst_out", {key_en, key_rel, key_ext, key_up, key_down, key_left, key_right, frame_err}, 0);
        iRST_n = 1'b1;
        wait_cyc(2);
        snap();
        // Remaining E0 bits: b3..b7, parity, stop; b3=0 starts a garbage frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(TO + 100);
        chk("rec_err", err_cnt - err0, 1);
        chk("rec_strobes", (en_cnt - en0) + (rel_cnt - rel0), 0);
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk("rec_en", en_cnt - en0, 1);
        chk("rec_key", 32'(key_in), 32'h6B);
        chk("rec_ext", 32'(key_ext), 1);
        chk("rec_left", 32'(key_left), 1);

        // Typematic repeat of non-extended 72
        snap();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h72, 1'b0);
            chk("rep_en_step", en_cnt - en0, i + 1);
        end
        chk("rep_down", 32'(key_down), 0);
        chk("rep_left_held", 32'(key_left), 1);
        chk("rep_ext", 32'(key_ext), 0);
        chk("rep_err", err_cnt - err0, 0);

        chk("strobe_exclusive", multi_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
